// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, controller numbers, FSM encodings
// and the data-byte count for a channel status byte.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHPR     = 4'hD;

    localparam int CC_VOLUME = 7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        WAIT_STATUS,
        WAIT_D1,
        WAIT_D2
    } parse_state_t;

    // Program Change and Channel Pressure carry one data byte, the other
    // channel messages two; system status bytes carry none we care about.
    function automatic logic [1:0] data_len(input logic [7:0] status);
        logic [1:0] len;
        if (status[7:4] == PROG || status[7:4] == CHPR) begin
            len = 2'd1;
        end else if (status[7] && status[7:4] != 4'hF) begin
            len = 2'd2;
        end else begin
            len = 2'd0;
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: 2-FF synchroniser, mid-bit sampling, one-cycle
// byte_valid / frame_err strobes.
module uart_rx_byte
    import midi_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 31250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int DIV   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             brk_q, brk_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            brk_q        <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            brk_q        <= brk_d;
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        brk_d        = brk_q;
        rx_meta_d    = uart_rx;
        rx_sync_d    = rx_meta_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // A start bit that is gone by mid-bit was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // After a framing error, hold here until the line returns high.
                if (brk_q) begin
                    if (rx_sync_q) begin
                        brk_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        brk_d       = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI input stage: serial receive, running-status parser with channel filter,
// and monophonic last-note-priority note/velocity/gate/volume registers.
module midi_rx_parser
    import midi_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 31250,
    parameter int CHANNEL   = 0,
    parameter int OMNI      = 0,
    parameter int VOL_CC    = CC_VOLUME,
    parameter int VOL_RESET = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [6:0] nota,
    output logic [6:0] velocidad,
    output logic [6:0] volumen,
    output logic       note_on,
    output logic       note_valid,
    output logic       frame_err
);

    localparam logic [3:0] CHAN_N    = 4'(CHANNEL);
    localparam logic [6:0] VOL_CC_N  = 7'(VOL_CC);
    localparam logic [6:0] VOL_RST_N = 7'(VOL_RESET);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       chan_ok;
    logic       is_note_off;

    parse_state_t pstate_q, pstate_d;
    logic [7:0]   status_q, status_d;
    logic [6:0]   data1_q, data1_d;
    logic [6:0]   nota_q, nota_d;
    logic [6:0]   vel_q, vel_d;
    logic [6:0]   vol_q, vol_d;
    logic         gate_q, gate_d;
    logic         note_valid_q, note_valid_d;

    uart_rx_byte #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate_q     <= WAIT_STATUS;
            status_q     <= '0;
            data1_q      <= '0;
            nota_q       <= '0;
            vel_q        <= '0;
            vol_q        <= VOL_RST_N;
            gate_q       <= 1'b0;
            note_valid_q <= 1'b0;
        end else begin
            pstate_q     <= pstate_d;
            status_q     <= status_d;
            data1_q      <= data1_d;
            nota_q       <= nota_d;
            vel_q        <= vel_d;
            vol_q        <= vol_d;
            gate_q       <= gate_d;
            note_valid_q <= note_valid_d;
        end
    end

    assign chan_ok     = (OMNI != 0) || (rx_byte[3:0] == CHAN_N);
    assign is_note_off = (status_q[7:4] == NOTE_OFF) ||
                         (status_q[7:4] == NOTE_ON && rx_byte[6:0] == 7'd0);

    always_comb begin
        pstate_d     = pstate_q;
        status_d     = status_q;
        data1_d      = data1_q;
        nota_d       = nota_q;
        vel_d        = vel_q;
        vol_d        = vol_q;
        gate_d       = gate_q;
        note_valid_d = 1'b0;

        if (byte_valid) begin
            if (rx_byte[7]) begin
                // Realtime bytes (F8-FF) are transparent to everything.
                if (rx_byte[7:3] != 5'b11111) begin
                    if (rx_byte[7:4] != 4'hF && chan_ok) begin
                        status_d = rx_byte;
                        pstate_d = WAIT_D1;
                    end else begin
                        pstate_d = WAIT_STATUS;
                    end
                end
            end else begin
                case (pstate_q)
                    WAIT_D1: begin
                        if (data_len(status_q) == 2'd2) begin
                            data1_d  = rx_byte[6:0];
                            pstate_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        pstate_d = WAIT_D1;
                        if (status_q[7:4] == NOTE_ON && !is_note_off) begin
                            nota_d       = data1_q;
                            vel_d        = rx_byte[6:0];
                            gate_d       = 1'b1;
                            note_valid_d = 1'b1;
                        end else if (is_note_off) begin
                            // Releasing a note other than the sounding one leaves the gate alone.
                            note_valid_d = 1'b1;
                            if (data1_q == nota_q) begin
                                gate_d = 1'b0;
                            end
                        end else if (status_q[7:4] == CC && data1_q == VOL_CC_N) begin
                            vol_d = rx_byte[6:0];
                        end
                    end
                    default: begin
                        pstate_d = WAIT_STATUS;
                    end
                endcase
            end
        end
    end

    assign nota       = nota_q;
    assign velocidad  = vel_q;
    assign volumen    = vol_q;
    assign note_on    = gate_q;
    assign note_valid = note_valid_q;

endmodule
